// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle control unit for the 4-bit CPU. Fetches 8-bit instructions
// from a synchronous ROM, decodes them and sequences the external
// combinational ALU and a synchronous data RAM. Holds the accumulator,
// carry flag and program counter.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   run_i                    start/resume pulse (honoured in IDLE/HALT)
//   pc_o, instr_i            instruction ROM address / data (1-cycle latency)
//   mem_addr_o, mem_we_o,
//   mem_wdata_o, mem_rdata_i data RAM port (1-cycle read latency)
//   alu_a_o, alu_b_o,
//   alu_oc_o                 ALU operands and operation code
//   alu_result_i, alu_carry_i ALU outputs (combinational)
//   acc_o, carry_o           architectural accumulator and carry flag
//   busy_o, halted_o         status
//
// state  | meaning
// IDLE   | after reset, waiting for run_i
// FETCH  | pc_o presented to the ROM
// DECODE | instr_i valid: latch opcode, advance or load pc
// MEM    | RAM address presented for a read operand
// EXEC   | ALU/RAM operation; acc/carry update on the closing edge
// HALT   | stopped after HLT, waiting for run_i to resume

module alu_sequencer #(
    parameter int ALU_BIT_WIDTH        = 4,
    parameter int OPERATION_CODE_WIDTH = 3,
    parameter int ADDR_WIDTH           = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            run_i,
    output logic [ADDR_WIDTH-1:0]           pc_o,
    input  logic [7:0]                      instr_i,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic                            mem_we_o,
    output logic [ALU_BIT_WIDTH-1:0]        mem_wdata_o,
    input  logic [ALU_BIT_WIDTH-1:0]        mem_rdata_i,
    output logic [ALU_BIT_WIDTH-1:0]        alu_a_o,
    output logic [ALU_BIT_WIDTH-1:0]        alu_b_o,
    output logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o,
    input  logic [ALU_BIT_WIDTH-1:0]        alu_result_i,
    input  logic                            alu_carry_i,
    output logic [ALU_BIT_WIDTH-1:0]        acc_o,
    output logic                            carry_o,
    output logic                            busy_o,
    output logic                            halted_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [2:0]               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
    logic [3:0]               op_q, op_d;
    logic [ALU_BIT_WIDTH-1:0] acc_q, acc_d;
    logic                     carry_q, carry_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;

    logic [3:0]               dec_op;
    logic [ADDR_WIDTH-1:0]    dec_x;

    assign dec_op = instr_i[7:4];
    assign dec_x  = ADDR_WIDTH'(instr_i[3:0]);

    function automatic logic [OPERATION_CODE_WIDTH-1:0] oc_of(input logic [3:0] op);
        logic [OPERATION_CODE_WIDTH-1:0] oc;
        oc = '0;
        case (op)
            OP_ADD:  oc = OPERATION_CODE_WIDTH'(3'b100);
            OP_ADDI: oc = OPERATION_CODE_WIDTH'(3'b101);
            OP_SUB:  oc = OPERATION_CODE_WIDTH'(3'b111);
            OP_SUBI: oc = OPERATION_CODE_WIDTH'(3'b110);
            OP_XOR:  oc = OPERATION_CODE_WIDTH'(3'b001);
            OP_AND:  oc = OPERATION_CODE_WIDTH'(3'b010);
            OP_OR:   oc = OPERATION_CODE_WIDTH'(3'b011);
            default: oc = '0;
        endcase
        return oc;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d    = dec_op;
                pc_d    = pc_q + 1'b1;
                state_d = S_FETCH;
                case (dec_op)
                    OP_JMP: pc_d = dec_x;
                    // JC sees the carry committed by the previous instruction.
                    OP_JC:  if (carry_q) pc_d = dec_x;
                    OP_HLT: state_d = S_HALT;
                    OP_LDA, OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: begin
                        addr_d  = dec_x;
                        state_d = S_MEM;
                    end
                    OP_ADDI, OP_SUBI, OP_STA: begin
                        addr_d  = dec_x;
                        state_d = S_EXEC;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_LDA: acc_d = mem_rdata_i;
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        acc_d   = alu_result_i;
                        carry_d = alu_carry_i;
                    end
                    OP_XOR, OP_AND, OP_OR: acc_d = alu_result_i;
                    default: acc_d = acc_q;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            op_q    <= OP_NOP;
            acc_q   <= '0;
            carry_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            addr_q  <= addr_d;
        end
    end

    // ALU and write-enable are decoded from the state register so that an
    // asynchronous reset drops them immediately, even mid-STA.
    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_oc_o = '0;
        mem_we_o = 1'b0;
        if (state_q == S_EXEC) begin
            alu_a_o  = acc_q;
            alu_b_o  = (op_q == OP_ADDI || op_q == OP_SUBI) ? ALU_BIT_WIDTH'(1) : mem_rdata_i;
            alu_oc_o = oc_of(op_q);
            mem_we_o = (op_q == OP_STA);
        end
    end

    assign pc_o        = pc_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = acc_q;
    assign acc_o       = acc_q;
    assign carry_o     = carry_q;
    assign busy_o      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_MEM)   || (state_q == S_EXEC);
    assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: instruction-level reference model expanded
// into an expected per-cycle output trace, directed programs from the
// test plan, and randomized programs with run_i noise while busy.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_i;
    logic [3:0] pc_o;
    logic [7:0] instr;
    logic [3:0] mem_addr_o;
    logic       mem_we_o;
    logic [3:0] mem_wdata_o;
    logic [3:0] rdata;
    logic [3:0] alu_a_o, alu_b_o;
    logic [2:0] alu_oc_o;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic [3:0] acc_o;
    logic       carry_o, busy_o, halted_o;

    always #5 clk = ~clk;

    alu_sequencer #(.ALU_BIT_WIDTH(4), .OPERATION_CODE_WIDTH(3), .ADDR_WIDTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run_i), .pc_o(pc_o), .instr_i(instr),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(rdata), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_oc_o(alu_oc_o),
        .alu_result_i(alu_result), .alu_carry_i(alu_carry), .acc_o(acc_o),
        .carry_o(carry_o), .busy_o(busy_o), .halted_o(halted_o)
    );

    // Environment ALU: add ops give carry-out, sub ops give carry = no borrow.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] oc);
        case (oc)
            3'b100, 3'b101: return {1'b0, a} + {1'b0, b};
            3'b111, 3'b110: return {(a >= b), 4'(a - b)};
            3'b001:         return {1'b0, a ^ b};
            3'b010:         return {1'b0, a & b};
            3'b011:         return {1'b0, a | b};
            default:        return 5'd0;
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_f(alu_a_o, alu_b_o, alu_oc_o);

    logic [7:0] rom [16];
    logic [3:0] ram [16];
    logic [3:0] ram_init [16];

    always @(posedge clk) instr <= rom[pc_o];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) ram[i] <= ram_init[i];
        end else if (mem_we_o) begin
            ram[mem_addr_o] <= mem_wdata_o;
        end
        rdata <= ram[mem_addr_o];
    end

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] acc;
        logic       carry;
        logic       busy;
        logic       halted;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] oc;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic care;   // ALU outputs checked on this cycle
    } exp_t;

    exp_t q[$];

    logic [3:0] m_pc, m_acc, m_addr;
    logic       m_carry;
    logic [3:0] m_ram [16];
    bit         m_halted;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  checking = 0;
    bit  noise_force = 0;
    int  busy_cnt, we_cnt;
    logic [3:0] we_addr, we_data, addi_b;
    bit  addi_seen;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic busy, input logic halted);
        exp_t e;
        e          = '0;
        e.o.pc     = m_pc;
        e.o.acc    = m_acc;
        e.o.carry  = m_carry;
        e.o.busy   = busy;
        e.o.halted = halted;
        e.o.addr   = m_addr;
        e.care     = 1'b1;
        return e;
    endfunction

    // Expand one instruction into its expected cycles and apply its effect.
    task automatic model_instr(output bit h);
        logic [7:0] ins;
        logic [3:0] op, x, b;
        logic [2:0] oc;
        logic [4:0] r;
        exp_t       e;
        ins = rom[m_pc];
        op  = ins[7:4];
        x   = ins[3:0];
        h   = 1'b0;
        q.push_back(mk(1'b1, 1'b0));
        q.push_back(mk(1'b1, 1'b0));
        if (op == 4'hA || (op == 4'hB && m_carry)) m_pc = x;
        else m_pc = m_pc + 4'd1;
        if (op == 4'hF) begin
            q.push_back(mk(1'b0, 1'b1));
            h = 1'b1;
        end else if (op >= 4'h1 && op <= 4'h9) begin
            m_addr = x;
            if (op inside {4'h1, 4'h3, 4'h5, 4'h7, 4'h8, 4'h9}) q.push_back(mk(1'b1, 1'b0));
            case (op)
                4'h3: oc = 3'b100;
                4'h4: oc = 3'b101;
                4'h5: oc = 3'b111;
                4'h6: oc = 3'b110;
                4'h7: oc = 3'b001;
                4'h8: oc = 3'b010;
                4'h9: oc = 3'b011;
                default: oc = 3'b000;
            endcase
            b = (op == 4'h4 || op == 4'h6) ? 4'd1 : m_ram[x];
            e = mk(1'b1, 1'b0);
            if (op == 4'h1 || op == 4'h2) begin
                e.care = 1'b0;
            end else begin
                e.o.a  = m_acc;
                e.o.b  = b;
                e.o.oc = oc;
            end
            if (op == 4'h2) begin
                e.o.we    = 1'b1;
                e.o.wdata = m_acc;
            end
            q.push_back(e);
            if (op == 4'h1) begin
                m_acc = m_ram[x];
            end else if (op == 4'h2) begin
                m_ram[x] = m_acc;
            end else begin
                r     = alu_f(m_acc, b, oc);
                m_acc = r[3:0];
                if (op inside {4'h3, 4'h4, 4'h5, 4'h6}) m_carry = r[4];
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        obs_t s;
        @(negedge clk);
        if (checking && q.size() > 0) begin
            e        = q.pop_front();
            s.pc     = pc_o;
            s.acc    = acc_o;
            s.carry  = carry_o;
            s.busy   = busy_o;
            s.halted = halted_o;
            s.we     = mem_we_o;
            s.addr   = mem_addr_o;
            s.wdata  = e.o.we ? mem_wdata_o : 4'd0;
            s.a      = e.care ? alu_a_o  : 4'd0;
            s.b      = e.care ? alu_b_o  : 4'd0;
            s.oc     = e.care ? alu_oc_o : 3'd0;
            n_checks++;
            if (s !== e.o) begin
                n_fail++;
                $display("FAIL trace t=%0t dut=%h model=%h", $time, s, e.o);
            end
            if (busy_o) busy_cnt++;
            if (mem_we_o) begin
                we_cnt++;
                we_addr = mem_addr_o;
                we_data = mem_wdata_o;
            end
            if (alu_oc_o == 3'b101) begin
                addi_seen = 1'b1;
                addi_b    = alu_b_o;
            end
            // run_i pulses while busy must be ignored.
            run_i = e.o.busy && (noise_force || $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic run_prog(input int max_i);
        bit h;
        int n;
        h = 1'b0;
        n = 0;
        for (int i = 0; i < max_i && !h; i++) model_instr(h);
        m_halted  = h;
        busy_cnt  = 0;
        we_cnt    = 0;
        addi_seen = 1'b0;
        @(negedge clk);
        run_i = 1'b1;
        @(posedge clk);
        #1;
        run_i    = 1'b0;
        checking = 1'b1;
        while (q.size() > 0 && n < 4 * max_i + 8) begin
            tick();
            n++;
        end
        checking = 1'b0;
        run_i    = 1'b0;
        chk("trace_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_values",
            int'({pc_o, acc_o, carry_o, mem_addr_o, mem_wdata_o, mem_we_o,
                  alu_a_o, alu_b_o, alu_oc_o, busy_o, halted_o}), 0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        m_pc     = 4'd0;
        m_acc    = 4'd0;
        m_carry  = 1'b0;
        m_addr   = 4'd0;
        m_halted = 1'b0;
        for (int i = 0; i < 16; i++) m_ram[i] = ram_init[i];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            rom[i]      = 8'hF0;
            ram_init[i] = 4'd0;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        run_i = 1'b0;
        clear_mem();
        #2;

        // LDA 3 / ADD 4 / HLT with run_i held high throughout busy cycles.
        rom[0] = 8'h13; rom[1] = 8'h34; rom[2] = 8'hF0;
        ram_init[3] = 4'b0010; ram_init[4] = 4'b1111;
        do_reset();
        noise_force = 1'b1;
        run_prog(10);
        noise_force = 1'b0;
        chk("t1_acc", acc_o, 1);
        chk("t1_carry", carry_o, 1);
        chk("t1_pc", pc_o, 3);
        chk("t1_halted", halted_o, 1);
        chk("t1_busy_cycles", busy_cnt, 10);
        chk("t1_model_acc", m_acc, 1);

        // Resume from HALT: SUBI then ADDI.
        rom[3] = 8'h60; rom[4] = 8'hF0; rom[5] = 8'h40; rom[6] = 8'hF0;
        run_prog(10);
        chk("t2_subi_acc", acc_o, 0);
        chk("t2_subi_carry", carry_o, 1);
        chk("t2_resume_pc", pc_o, 5);
        run_prog(10);
        chk("t2_addi_acc", acc_o, 1);
        chk("t2_addi_carry", carry_o, 0);
        chk("t2_addi_oc_seen", addi_seen, 1);
        chk("t2_addi_b", addi_b, 1);

        // Logic ops from acc=1001 with carry preset to 1.
        clear_mem();
        rom[0] = 8'h18; rom[1] = 8'h40; rom[2] = 8'h16; rom[3] = 8'h75; rom[4] = 8'hF0;
        rom[5] = 8'h16; rom[6] = 8'h85; rom[7] = 8'hF0;
        rom[8] = 8'h16; rom[9] = 8'h95; rom[10] = 8'hF0;
        ram_init[5] = 4'b1010; ram_init[6] = 4'b1001; ram_init[8] = 4'b1111;
        do_reset();
        run_prog(10);
        chk("t3_xor_acc", acc_o, 4'b0011);
        chk("t3_xor_carry", carry_o, 1);
        run_prog(10);
        chk("t3_and_acc", acc_o, 4'b1000);
        run_prog(10);
        chk("t3_or_acc", acc_o, 4'b1011);
        chk("t3_or_carry", carry_o, 1);

        // STA 7 with acc=0110.
        clear_mem();
        rom[0] = 8'h12; rom[1] = 8'h27; rom[2] = 8'hF0;
        ram_init[2] = 4'b0110;
        do_reset();
        run_prog(10);
        chk("t4_we_cycles", we_cnt, 1);
        chk("t4_we_addr", we_addr, 7);
        chk("t4_we_data", we_data, 4'b0110);
        chk("t4_acc", acc_o, 4'b0110);
        chk("t4_ram7", ram[7], 4'b0110);

        // Reset asserted during the EXEC cycle of STA.
        ram_init[7] = 4'd3;
        do_reset();
        run_prog(2);
        chk("t7_we_before_reset", mem_we_o, 1);
        #1;
        do_reset();
        repeat (3) tick();
        chk("t7_idle_after_release", {busy_o, halted_o, pc_o}, 0);

        // JC fall-through, JC taken, NOP wrap at pc 15.
        clear_mem();
        rom[0] = 8'hB9; rom[1] = 8'h18; rom[2] = 8'h40; rom[3] = 8'hB9;
        rom[9] = 8'hF0; rom[10] = 8'hAF; rom[15] = 8'h00;
        ram_init[8] = 4'hF;
        do_reset();
        run_prog(10);
        chk("t5_jc_pc", pc_o, 10);
        chk("t5_jc_carry", carry_o, 1);
        run_prog(10);
        chk("t5_wrap_pc", pc_o, 10);
        chk("t5_wrap_halted", halted_o, 1);

        // Randomized programs.
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i] = 8'($urandom);
                if ($urandom_range(0, 7) == 0) rom[i] = 8'hF0;
                ram_init[i] = 4'($urandom);
            end
            do_reset();
            run_prog(30);
            if (m_halted) run_prog(30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
